// File: rtl/id_pipe_if.sv
// ID -> EX handshake bundle: the ID/EX pipeline register contents plus valid/ready.
interface id_pipe_if #(
    parameter int InstAddrBus = 32,
    parameter int RegAddrBus  = 5,
    parameter int RegBus      = 32,
    parameter int AluOpBus    = 8,
    parameter int AluSelBus   = 3
);
    logic                   valid;
    logic                   ready;
    logic [AluOpBus-1:0]    aluop;
    logic [AluSelBus-1:0]   alusel;
    logic [RegBus-1:0]      reg1_data;
    logic [RegBus-1:0]      reg2_data;
    logic [RegAddrBus-1:0]  w_addr;
    logic                   wreg;
    logic [InstAddrBus-1:0] pc;

    modport master (
        output valid, aluop, alusel, reg1_data, reg2_data, w_addr, wreg, pc,
        input  ready
    );

    modport slave (
        input  valid, aluop, alusel, reg1_data, reg2_data, w_addr, wreg, pc,
        output ready
    );
endinterface

// File: rtl/id_pipe.sv
// Registered MIPS decode stage: operand forwarding from EX/MEM, load-use stall,
// and an ID/EX register handed to execute over a valid/ready handshake.
module id_pipe #(
    parameter int InstAddrBus = 32,
    parameter int InstBus     = 32,
    parameter int RegAddrBus  = 5,
    parameter int RegBus      = 32,
    parameter int AluOpBus    = 8,
    parameter int AluSelBus   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    output logic                   id_ready_o,
    input  logic [InstAddrBus-1:0] id_pc_i,
    input  logic [InstBus-1:0]     id_inst_i,
    output logic                   reg1_ren_o,
    output logic                   reg2_ren_o,
    output logic [RegAddrBus-1:0]  reg1_addr_o,
    output logic [RegAddrBus-1:0]  reg2_addr_o,
    input  logic [RegBus-1:0]      reg1_data_i,
    input  logic [RegBus-1:0]      reg2_data_i,
    input  logic                   ex_wreg_i,
    input  logic [RegAddrBus-1:0]  ex_waddr_i,
    input  logic [RegBus-1:0]      ex_wdata_i,
    input  logic                   ex_is_load_i,
    input  logic                   mem_wreg_i,
    input  logic [RegAddrBus-1:0]  mem_waddr_i,
    input  logic [RegBus-1:0]      mem_wdata_i,
    input  logic                   flush_i,
    id_pipe_if.master              ex
);
    localparam logic [AluSelBus-1:0] SEL_LOGIC = AluSelBus'(1);
    localparam logic [AluSelBus-1:0] SEL_ARITH = AluSelBus'(4);
    localparam logic [AluSelBus-1:0] SEL_LOAD  = AluSelBus'(7);

    typedef struct packed {
        logic [AluOpBus-1:0]    aluop;
        logic [AluSelBus-1:0]   alusel;
        logic [RegBus-1:0]      reg1_data;
        logic [RegBus-1:0]      reg2_data;
        logic [RegAddrBus-1:0]  w_addr;
        logic                   wreg;
        logic [InstAddrBus-1:0] pc;
    } idex_t;

    logic [5:0]            opc, funct;
    logic [RegAddrBus-1:0] rs, rt, rd;
    logic [15:0]           imm16;
    logic                  unused_sa;

    assign opc       = id_inst_i[31:26];
    assign rs        = id_inst_i[25:21];
    assign rt        = id_inst_i[20:16];
    assign rd        = id_inst_i[15:11];
    assign funct     = id_inst_i[5:0];
    assign imm16     = id_inst_i[15:0];
    assign unused_sa = ^id_inst_i[10:6];

    logic [AluOpBus-1:0]   aluop;
    logic [AluSelBus-1:0]  alusel;
    logic                  wreg, ren1, ren2;
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     imm;

    always_comb begin
        aluop  = '0;
        alusel = '0;
        wreg   = 1'b0;
        waddr  = '0;
        ren1   = 1'b0;
        ren2   = 1'b0;
        imm    = '0;
        case (opc)
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23: begin
                        aluop  = AluOpBus'(funct);
                        alusel = funct[2] ? SEL_LOGIC : SEL_ARITH;
                        wreg   = 1'b1;
                        waddr  = rd;
                        ren1   = 1'b1;
                        ren2   = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                // ANDI/ORI/XORI share the R-type logic aluops
                aluop  = (opc == 6'h0C) ? AluOpBus'(8'h24) :
                         (opc == 6'h0D) ? AluOpBus'(8'h25) : AluOpBus'(8'h26);
                alusel = SEL_LOGIC;
                wreg   = 1'b1;
                waddr  = rt;
                ren1   = 1'b1;
                imm    = RegBus'(imm16);
            end
            6'h0F: begin
                aluop  = AluOpBus'(8'h0F);
                alusel = SEL_LOGIC;
                wreg   = 1'b1;
                waddr  = rt;
                imm    = RegBus'({imm16, 16'h0000});
            end
            6'h09, 6'h23: begin
                aluop  = (opc == 6'h09) ? AluOpBus'(8'h21) : AluOpBus'(8'hE3);
                alusel = (opc == 6'h09) ? SEL_ARITH : SEL_LOAD;
                wreg   = 1'b1;
                waddr  = rt;
                ren1   = 1'b1;
                imm    = {{(RegBus-16){imm16[15]}}, imm16};
            end
            default: ;
        endcase
    end

    assign reg1_ren_o  = ren1;
    assign reg2_ren_o  = ren2;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    // A load still in EX has no data yet, so only MEM or the regfile can supply it
    function automatic logic [RegBus-1:0] resolve(input logic ren,
                                                  input logic [RegAddrBus-1:0] a,
                                                  input logic [RegBus-1:0] rf);
        if (!ren || a == '0)                                    return '0;
        else if (ex_wreg_i && ex_waddr_i == a && !ex_is_load_i) return ex_wdata_i;
        else if (mem_wreg_i && mem_waddr_i == a)                return mem_wdata_i;
        else                                                    return rf;
    endfunction

    logic [RegBus-1:0] op1, op2;
    assign op1 = resolve(ren1, rs, reg1_data_i);
    assign op2 = ren2 ? resolve(ren2, rt, reg2_data_i) : imm;

    logic hazard, load_en, issue, vld;
    assign hazard  = ex_is_load_i && ex_wreg_i && (ex_waddr_i != '0) &&
                     ((ren1 && ex_waddr_i == rs) || (ren2 && ex_waddr_i == rt));
    assign load_en = !vld || ex.ready;
    assign issue   = id_valid_i && !hazard && !flush_i;

    assign id_ready_o = flush_i || (load_en && !hazard);

    idex_t dec, q;
    assign dec = {aluop, alusel, op1, op2, waddr, wreg, id_pc_i};

    // Flush must kill the register even while EX is back-pressuring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load_en || flush_i) begin
            vld <= issue;
            q   <= issue ? dec : '0;
        end
    end

    assign ex.valid     = vld;
    assign ex.aluop     = q.aluop;
    assign ex.alusel    = q.alusel;
    assign ex.reg1_data = q.reg1_data;
    assign ex.reg2_data = q.reg2_data;
    assign ex.w_addr    = q.w_addr;
    assign ex.wreg      = q.wreg;
    assign ex.pc        = q.pc;
endmodule

// File: tb/tb_id_pipe.sv
// Randomized + directed bench for id_pipe against an instruction-level reference model.
module tb_id_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid_i, id_ready_o;
    logic [31:0] id_pc_i, id_inst_i;
    logic        reg1_ren_o, reg2_ren_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, mem_wreg_i, ex_is_load_i, flush_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;

    always #5 clk = ~clk;

    id_pipe_if #(.InstAddrBus(32), .RegAddrBus(5), .RegBus(32), .AluOpBus(8), .AluSelBus(3)) exb ();

    id_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i), .id_inst_i(id_inst_i),
        .reg1_ren_o(reg1_ren_o), .reg2_ren_o(reg2_ren_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .ex(exb)
    );

    int n_run = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  sel;
        logic        wr;
        logic [4:0]  wa;
        logic        u1, u2;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [7:0]  aluop;
        logic [2:0]  sel;
        logic [31:0] op1, op2;
        logic [4:0]  wa;
        logic        wr;
        logic [31:0] pc;
    } mst_t;

    mst_t m;

    // Instruction semantics by mnemonic
    function automatic dec_t mdec(input logic [31:0] i);
        dec_t d;
        logic [5:0]  op, fn;
        logic [15:0] im;
        d  = '0;
        op = i[31:26];
        fn = i[5:0];
        im = i[15:0];
        if (op == 6'h00) begin
            if (fn inside {6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23}) begin
                d.aluop = {2'b00, fn};
                d.sel   = (fn >= 6'h24) ? 3'd1 : 3'd4;
                d.wr = 1'b1; d.wa = i[15:11]; d.u1 = 1'b1; d.u2 = 1'b1;
            end
        end else begin
            d.wr = 1'b1; d.wa = i[20:16]; d.u1 = 1'b1;
            case (op)
                6'h0C:   begin d.aluop = 8'h24; d.sel = 3'd1; d.imm = {16'h0, im}; end
                6'h0D:   begin d.aluop = 8'h25; d.sel = 3'd1; d.imm = {16'h0, im}; end
                6'h0E:   begin d.aluop = 8'h26; d.sel = 3'd1; d.imm = {16'h0, im}; end
                6'h0F:   begin d.aluop = 8'h0F; d.sel = 3'd1; d.imm = {im, 16'h0}; d.u1 = 1'b0; end
                6'h09:   begin d.aluop = 8'h21; d.sel = 3'd4; d.imm = {{16{im[15]}}, im}; end
                6'h23:   begin d.aluop = 8'hE3; d.sel = 3'd7; d.imm = {{16{im[15]}}, im}; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] mres(input logic u, input logic [4:0] a, input logic [31:0] rf);
        if (!u || a == 5'd0) return 32'd0;
        if (ex_wreg_i && !ex_is_load_i && ex_waddr_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_waddr_i == a) return mem_wdata_i;
        return rf;
    endfunction

    // One cycle: check combinational outputs, advance model, check register
    task automatic step();
        dec_t d;
        logic hz, le, iss;
        #1;
        d  = mdec(id_inst_i);
        hz = ex_is_load_i && ex_wreg_i && ex_waddr_i != 5'd0 &&
             ((d.u1 && ex_waddr_i == id_inst_i[25:21]) || (d.u2 && ex_waddr_i == id_inst_i[20:16]));
        le = !m.v || exb.ready;
        chk("id_ready", id_ready_o, flush_i || (le && !hz));
        chk("ren", {reg1_ren_o, reg2_ren_o}, {d.u1, d.u2});
        chk("raddr", {reg1_addr_o, reg2_addr_o}, id_inst_i[25:16]);
        iss = id_valid_i && !hz && !flush_i;
        if (le || flush_i) begin
            m = '0;
            if (iss) begin
                m.v = 1'b1; m.aluop = d.aluop; m.sel = d.sel;
                m.op1 = mres(d.u1, id_inst_i[25:21], reg1_data_i);
                m.op2 = d.u2 ? mres(d.u2, id_inst_i[20:16], reg2_data_i) : d.imm;
                m.wa = d.wa; m.wr = d.wr; m.pc = id_pc_i;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", exb.valid, m.v);
        chk("aluop", exb.aluop, m.aluop);
        chk("alusel", exb.alusel, m.sel);
        chk("op1", exb.reg1_data, m.op1);
        chk("op2", exb.reg2_data, m.op2);
        chk("w_addr", exb.w_addr, m.wa);
        chk("wreg", exb.wreg, m.wr);
        chk("pc", exb.pc, m.pc);
    endtask

    task automatic clr_fwd();
        ex_wreg_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [5:0]  fns [6] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23};
        logic [5:0]  ops [6] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h09, 6'h23};
        int k;
        k = $urandom_range(0, 12);
        i = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        if (k < 6)       i = {6'h00, i[25:16], 5'($urandom_range(0, 7)), 5'd0, fns[k]};
        else if (k < 12) i[31:26] = ops[k-6];
        else             i = $urandom;
        return i;
    endfunction

    initial begin
        m = '0;
        id_valid_i = 0; id_pc_i = 0; id_inst_i = 0;
        reg1_data_i = 0; reg2_data_i = 0; flush_i = 0;
        exb.ready = 1'b1;
        clr_fwd();
        #12;
        chk("rst_valid", exb.valid, 1'b0);
        chk("rst_aluop", exb.aluop, 8'h00);
        chk("rst_op2", exb.reg2_data, 32'h0);
        rst_n = 1'b1;

        // ori $1,$0,0x1100
        id_valid_i = 1; id_pc_i = 32'h100; id_inst_i = 32'h3401_1100;
        step();
        chk("ori_aluop", exb.aluop, 8'h25);
        chk("ori_imm", exb.reg2_data, 32'h0000_1100);
        chk("ori_dst", {exb.w_addr, exb.wreg, exb.alusel}, {5'd1, 1'b1, 3'd1});

        // addu $3,$1,$2: EX beats MEM/regfile for $1, MEM supplies $2
        id_pc_i = 32'h104; id_inst_i = 32'h0022_1821;
        ex_wreg_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h5;
        mem_wreg_i = 1; mem_waddr_i = 2; mem_wdata_i = 32'h7;
        reg1_data_i = 32'h9; reg2_data_i = 32'h33;
        step();
        chk("fwd_ex", exb.reg1_data, 32'h5);
        chk("fwd_mem", exb.reg2_data, 32'h7);
        clr_fwd();

        id_pc_i = 32'h108; id_inst_i = 32'h2402_FFFF;
        step();
        chk("addiu_sext", exb.reg2_data, 32'hFFFF_FFFF);
        id_pc_i = 32'h10C; id_inst_i = 32'h3C04_8000; reg1_data_i = 32'h1234;
        #1 chk("lui_ren", reg1_ren_o, 1'b0);
        step();
        chk("lui_imm", exb.reg2_data, 32'h8000_0000);

        // load-use: EX is lw $5, ID holds or $6,$5,$0
        ex_wreg_i = 1; ex_waddr_i = 5; ex_is_load_i = 1; ex_wdata_i = 32'hDEAD;
        id_pc_i = 32'h110; id_inst_i = 32'h00A0_3025;
        #1 chk("lu_ready", id_ready_o, 1'b0);
        step();
        chk("lu_bubble", {exb.valid, exb.wreg, exb.aluop}, 10'd0);
        clr_fwd();
        mem_wreg_i = 1; mem_waddr_i = 5; mem_wdata_i = 32'hABCD;
        step();
        chk("lu_issue", {exb.valid, exb.reg1_data}, {1'b1, 32'hABCD});
        clr_fwd();

        // back-pressure for three cycles
        id_pc_i = 32'h200; id_inst_i = 32'h3407_0077;
        step();
        exb.ready = 1'b0;
        id_pc_i = 32'h204; id_inst_i = 32'h3408_0088;
        #1 chk("stall_ready", id_ready_o, 1'b0);
        repeat (3) step();
        chk("stall_pc", exb.pc, 32'h200);
        exb.ready = 1'b1;
        step();
        chk("release_pc", exb.pc, 32'h204);

        // flush under back-pressure
        exb.ready = 1'b0; flush_i = 1;
        #1 chk("flush_ready", id_ready_o, 1'b1);
        step();
        chk("flush_valid", exb.valid, 1'b0);
        flush_i = 0; exb.ready = 1'b1;

        // asynchronous reset mid-stream
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clear", {exb.valid, exb.wreg, exb.aluop, exb.reg2_data, exb.pc}, 74'd0);
        m = '0;
        #1 rst_n = 1'b1;

        repeat (400) begin
            id_valid_i   = ($urandom_range(0, 4) != 0);
            id_pc_i      = $urandom & 32'hFFFF_FFFC;
            id_inst_i    = rand_inst();
            reg1_data_i  = $urandom;
            reg2_data_i  = $urandom;
            ex_wreg_i    = $urandom_range(0, 1);
            ex_waddr_i   = 5'($urandom_range(0, 7));
            ex_wdata_i   = $urandom;
            ex_is_load_i = ($urandom_range(0, 3) == 0);
            mem_wreg_i   = $urandom_range(0, 1);
            mem_waddr_i  = 5'($urandom_range(0, 7));
            mem_wdata_i  = $urandom;
            flush_i      = ($urandom_range(0, 15) == 0);
            exb.ready    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
